// File: rtl/pixel_accum_if.sv
// Op/result bundle between the scan controller, the pixel RAM and the quantiser.
// The master side issues ops and clear requests; the slave side is the RAM.
interface pixel_accum_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int ERR_W    = 10,
  parameter int ADDR_W   = 13
);
  logic                       clear_req;
  logic                       busy;
  logic                       op_valid;
  logic                       op_ready;
  logic [1:0]                 op_mode;
  logic [ADDR_W-1:0]          op_addr;
  logic [CHANNELS*DATA_W-1:0] op_data;
  logic [CHANNELS*ERR_W-1:0]  op_err;
  logic                       rd_valid;
  logic [CHANNELS*DATA_W-1:0] rd_data;
  logic                       addr_err;

  modport master (
    output clear_req, op_valid, op_mode, op_addr, op_data, op_err,
    input  busy, op_ready, rd_valid, rd_data, addr_err
  );

  modport slave (
    input  clear_req, op_valid, op_mode, op_addr, op_data, op_err,
    output busy, op_ready, rd_valid, rd_data, addr_err
  );
endinterface

// File: rtl/pixel_accum_ram.sv
// Multi-channel pixel RAM with saturating error accumulate, clear sweep
// and single-stage bypass so back-to-back ops behave sequentially.
module pixel_accum_ram #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int ERR_W    = 10,
  parameter int IMAGEX   = 64,
  parameter int IMAGEY   = 64,
  parameter int DEPTH    = IMAGEX*IMAGEY,
  parameter int ADDR_W   = $clog2(DEPTH)+1
) (
  input logic clk,
  input logic reset,
  pixel_accum_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int WW    = CHANNELS*DATA_W;
  localparam int EW    = CHANNELS*ERR_W;
  localparam int SW    = ((DATA_W > ERR_W) ? DATA_W : ERR_W) + 2;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << DATA_W) - 1);
  localparam logic [1:0] M_WR = 2'b00;
  localparam logic [1:0] M_AC = 2'b01;
  localparam logic [1:0] M_RD = 2'b10;

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n;
  logic             dcnt, dcnt_n;

  logic             busy, acc, clr_acc, in_oob;
  logic [IDX_W-1:0] in_idx;

  logic [WW-1:0]    mem [DEPTH];
  logic [WW-1:0]    rdq, byp_val;
  logic             byp_hit;

  logic             p_valid, p_oob;
  logic [1:0]       p_mode;
  logic [IDX_W-1:0] p_addr;
  logic [WW-1:0]    p_data;
  logic [EW-1:0]    p_err;

  logic [WW-1:0]    old_w, acc_w, new_w;
  logic             p_wr, p_rd;
  logic signed [SW-1:0] sum;
  logic [DATA_W-1:0] ov;
  logic [ERR_W-1:0]  ev;

  logic             rd_valid_q, addr_err_q;
  logic [WW-1:0]    rd_data_q;

  assign busy    = (state != RUN);
  assign acc     = bus.op_valid & ~busy;
  assign clr_acc = bus.clear_req & ~busy;
  assign in_oob  = bus.op_addr >= ADDR_W'(DEPTH);
  assign in_idx  = bus.op_addr[IDX_W-1:0];

  assign bus.busy     = busy;
  assign bus.op_ready = ~busy;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.addr_err = addr_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      dcnt  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dcnt  <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dcnt_n  = dcnt;
    unique case (state)
      CLEAR: begin
        cnt_n = cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH-1)) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        if (bus.clear_req) begin
          state_n = DRAIN;
          dcnt_n  = 1'b0;
        end
      end
      DRAIN: begin
        dcnt_n = 1'b1;
        if (dcnt) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  // Op N-1 writes back on the same edge op N reads the array,
  // so its merged word is captured alongside the array read.
  assign old_w = byp_hit ? byp_val : rdq;
  assign p_wr  = p_valid & ~p_oob & ((p_mode == M_WR) | (p_mode == M_AC));
  assign p_rd  = p_valid & ((p_mode == M_RD) | (p_mode == M_AC));
  assign new_w = (p_mode == M_WR) ? p_data : acc_w;

  always_comb begin
    acc_w = '0;
    sum   = '0;
    ov    = '0;
    ev    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ov  = old_w[c*DATA_W +: DATA_W];
      ev  = p_err[c*ERR_W +: ERR_W];
      sum = $signed({{(SW-DATA_W){1'b0}}, ov})
          + $signed({{(SW-ERR_W){ev[ERR_W-1]}}, ev});
      if (sum < 0)
        acc_w[c*DATA_W +: DATA_W] = '0;
      else if (sum > MAXV)
        acc_w[c*DATA_W +: DATA_W] = {DATA_W{1'b1}};
      else
        acc_w[c*DATA_W +: DATA_W] = sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cnt] <= '0;
    else if (p_wr)
      mem[p_addr] <= new_w;
    rdq     <= mem[in_idx];
    byp_hit <= p_wr & (p_addr == in_idx);
    byp_val <= new_w;
    p_mode  <= bus.op_mode;
    p_addr  <= in_idx;
    p_oob   <= in_oob;
    p_data  <= bus.op_data;
    p_err   <= bus.op_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      p_valid    <= acc;
      rd_valid_q <= p_rd;
      if (p_rd)
        rd_data_q <= p_oob ? '0 : ((p_mode == M_RD) ? old_w : acc_w);
      if (clr_acc)
        addr_err_q <= 1'b0;
      else if (acc & in_oob)
        addr_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pixel_accum_ram.sv
// Directed bench for pixel_accum_ram: vector table for the op stream,
// hand sequences for sweep timing, drain and reset-mid-sweep.
module tb_pixel_accum_ram;
  localparam int AW = 13;

  typedef struct {
    logic [1:0]  mode;
    logic [12:0] addr;
    logic [23:0] data;
    logic [29:0] err;
    logic        rv;
    logic [23:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pixel_accum_if #(.DATA_W(8), .CHANNELS(3), .ERR_W(10), .ADDR_W(AW)) bus ();

  pixel_accum_ram #(
    .DATA_W(8), .CHANNELS(3), .ERR_W(10),
    .IMAGEX(64), .IMAGEY(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [29:0] mkerr(input int e2, input int e1,
                                        input int e0);
    return {10'(e2), 10'(e1), 10'(e0)};
  endfunction

  function automatic vec_t mkv(input logic [1:0] m, input int a,
                               input logic [23:0] d, input logic [29:0] e,
                               input logic rv, input logic [23:0] rd);
    vec_t v;
    v.mode = m; v.addr = 13'(a); v.data = d; v.err = e;
    v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic idle();
    bus.op_valid  = 1'b0;
    bus.clear_req = 1'b0;
    bus.op_mode   = 2'b11;
    bus.op_addr   = '0;
    bus.op_data   = '0;
    bus.op_err    = '0;
  endtask

  task automatic drive(input logic [1:0] m, input logic [12:0] a,
                       input logic [23:0] d, input logic [29:0] e);
    bus.op_valid = 1'b1;
    bus.op_mode  = m;
    bus.op_addr  = a;
    bus.op_data  = d;
    bus.op_err   = e;
  endtask

  task automatic do_op(input logic [1:0] m, input logic [12:0] a,
                       input logic [23:0] d, input logic [29:0] e,
                       output logic rv, output logic [23:0] rd);
    @(negedge clk);
    drive(m, a, d, e);
    @(negedge clk);
    idle();
    @(negedge clk);
    rv = bus.rd_valid;
    rd = bus.rd_data;
  endtask

  task automatic count_busy(input string nm, input int exp);
    int c;
    c = 0;
    while (bus.busy && c < 10000) begin
      @(negedge clk);
      c++;
    end
    chk(nm, c, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    logic rv;
    logic [23:0] rd;
    int n;
    int c;

    idle();
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1);
    chk("rst_ready", bus.op_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_addr_err", bus.addr_err, 0);

    reset = 1'b0;
    count_busy("init_sweep_len", 4096);
    chk("ready_after_sweep", bus.op_ready, 1);

    vecs.push_back(mkv(2'b10, 0,    0, 0, 1, 24'h000000));
    vecs.push_back(mkv(2'b10, 4095, 0, 0, 1, 24'h000000));
    vecs.push_back(mkv(2'b00, 5, 24'h8040FF, 0, 0, 0));
    vecs.push_back(mkv(2'b10, 5,    0, 0, 1, 24'h8040FF));
    vecs.push_back(mkv(2'b00, 7, 24'h10F080, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 7, 0, mkerr(20, 20, -200), 1, 24'h24FF00));
    vecs.push_back(mkv(2'b01, 7, 0, mkerr(-30, 0, 0), 1, 24'h06FF00));
    vecs.push_back(mkv(2'b01, 7, 0, mkerr(5, -10, 300), 1, 24'h0BF5FF));
    vecs.push_back(mkv(2'b11, 7, 24'hFFFFFF, 0, 0, 0));
    vecs.push_back(mkv(2'b10, 7,    0, 0, 1, 24'h0BF5FF));
    vecs.push_back(mkv(2'b00, 9, 24'h010203, 0, 0, 0));
    vecs.push_back(mkv(2'b11, 9, 24'hFFFFFF, 0, 0, 0));
    vecs.push_back(mkv(2'b10, 9,    0, 0, 1, 24'h010203));
    vecs.push_back(mkv(2'b01, 9, 0, mkerr(-1, 0, 252), 1, 24'h0002FF));
    vecs.push_back(mkv(2'b10, 4096, 0, 0, 1, 24'h000000));
    vecs.push_back(mkv(2'b10, 4095, 0, 0, 1, 24'h000000));
    vecs.push_back(mkv(2'b01, 4096, 0, mkerr(5, 5, 5), 1, 24'h000000));
    vecs.push_back(mkv(2'b00, 4096, 24'hABCDEF, 0, 0, 0));
    vecs.push_back(mkv(2'b10, 9,    0, 0, 1, 24'h0002FF));
    vecs.push_back(mkv(2'b10, 0,    0, 0, 1, 24'h000000));

    chk("addr_err_before_oob", bus.addr_err, 0);
    n = vecs.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("v%0d_rd_valid", k-2), bus.rd_valid, vecs[k-2].rv);
        if (vecs[k-2].rv)
          chk($sformatf("v%0d_rd_data", k-2), bus.rd_data, vecs[k-2].rd);
      end
      if (k < n) drive(vecs[k].mode, vecs[k].addr, vecs[k].data, vecs[k].err);
      else idle();
    end
    chk("addr_err_sticky", bus.addr_err, 1);
    chk("rd_data_hold", bus.rd_data, 24'h000000);

    // ACCUM together with clear_req: op completes, then drain and sweep
    @(negedge clk);
    drive(2'b01, 13'd5, 0, mkerr(1, 0, 0));
    bus.clear_req = 1'b1;
    @(negedge clk);
    idle();
    chk("drain_busy", bus.busy, 1);
    chk("drain_no_early_rv", bus.rd_valid, 0);
    @(negedge clk);
    chk("drain_rd_valid", bus.rd_valid, 1);
    chk("drain_rd_data", bus.rd_data, 24'h8140FF);
    c = 2;
    while (bus.busy && c < 10000) begin
      @(negedge clk);
      if (bus.busy) c++;
    end
    chk("drain_busy_len", c, 4098);
    chk("addr_err_cleared", bus.addr_err, 0);
    do_op(2'b10, 13'd5, 0, 0, rv, rd);
    chk("zero5_rv", rv, 1);
    chk("zero5_rd", rd, 0);
    do_op(2'b10, 13'd7, 0, 0, rv, rd);
    chk("zero7_rd", rd, 0);
    do_op(2'b10, 13'd9, 0, 0, rv, rd);
    chk("zero9_rd", rd, 0);

    // reset with a READ in flight: it must never return
    do_op(2'b00, 13'd3, 24'hAABBCC, 0, rv, rd);
    @(negedge clk);
    drive(2'b10, 13'd3, 0, 0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    chk("midop_rst_rv", bus.rd_valid, 0);
    @(negedge clk);
    chk("midop_rst_rv2", bus.rd_valid, 0);
    chk("midop_rst_busy", bus.busy, 1);
    @(negedge clk);
    reset = 1'b0;
    count_busy("midop_sweep_len", 4096);
    do_op(2'b10, 13'd3, 0, 0, rv, rd);
    chk("midop_zero3", rd, 0);

    // reset at sweep counter 1000: full sweep restarts
    do_op(2'b00, 13'd3, 24'h123456, 0, rv, rd);
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    repeat (1002) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("sweep_rst_busy", bus.busy, 1);
    chk("sweep_rst_ready", bus.op_ready, 0);
    reset = 1'b0;
    count_busy("restart_sweep_len", 4096);
    do_op(2'b10, 13'd3, 0, 0, rv, rd);
    chk("restart_zero3_rv", rv, 1);
    chk("restart_zero3", rd, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pixel_accum_ram.md
Name: pixel_accum_ram

Overview:
Parametrised multi-channel pixel RAM for the Floyd-Steinberg error-diffusion datapath. It replaces the single-channel read/write RAM with several added features:
- CHANNELS packed colour channels per word.
- A saturating read-modify-write "accumulate" op that adds signed diffusion error to a stored pixel.
- A hardware clear sweep.
- Full read-after-write bypass, so back-to-back ops to neighbouring or identical pixels need no stalls.

It sits between the scan controller (op source) and the quantiser (rd consumer).

Parameters:
DATA_W, 8, bits per colour channel (unsigned pixel value)
CHANNELS, 3, channels packed per word; channel c occupies bits [c*DATA_W +: DATA_W]
ERR_W, 10, bits per channel of signed error (two's complement)
IMAGEX, 64, image width in pixels
IMAGEY, 64, image height in pixels
DEPTH, IMAGEX*IMAGEY, number of words
ADDR_W, $clog2(DEPTH)+1, address width (one spare bit, so out-of-range addresses are representable)

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
clear_req  in  1  pulse: zero whole memory; ignored while busy=1
busy  out  1  1 while clear sweep active or pending
op_valid  in  1  op request
op_ready  out  1  equals !busy; op accepted when op_valid & op_ready
op_mode  in  2  00 WRITE, 01 ACCUM, 10 READ, 11 reserved (treated as NOP)
op_addr  in  ADDR_W  pixel address, row-major (y*IMAGEX+x)
op_data  in  CHANNELS*DATA_W  write data (WRITE only)
op_err  in  CHANNELS*ERR_W  signed per-channel error (ACCUM only)
rd_valid  out  1  rd_data valid this cycle
rd_data  out  CHANNELS*DATA_W  READ: stored word; ACCUM: post-update word
addr_err  out  1  sticky; set when an op is accepted with op_addr >= DEPTH; cleared by reset or clear_req acceptance

Behaviour:
- Reset (async assert) forces the following immediately:
  - busy=1, op_ready=0, rd_valid=0, rd_data=0, addr_err=0.
  - Pipeline valids cleared; in-flight ops dropped.
  - FSM=CLEAR, sweep counter=0.
  - Memory array itself is not reset.
- FSM states:
  - CLEAR: writes all-zero word to addr = counter each cycle, counter++; after writing DEPTH-1, go to RUN. Duration DEPTH cycles after reset release. busy=1 throughout.
  - RUN: busy=0; ops accepted every cycle (no back-pressure).
  - DRAIN: entered from RUN on clear_req=1. busy=1, no new ops. Stays 2 cycles while in-flight ops complete (their rd_valid still fires), then goes to CLEAR with counter=0.
- Pipeline for an op accepted at cycle N:
  - N: address/mode registered.
  - N+1: synchronous array read.
  - N+2: merge/saturate; WRITE/ACCUM writeback to the array; rd_valid=1 with rd_data for READ/ACCUM.
  - Latency is uniformly 2 for READ and ACCUM. WRITE and NOP never raise rd_valid.
- Ordering: the result must equal strictly sequential execution in acceptance order. Any op reading an address written by either of the two preceding accepted ops takes the youngest in-flight value via bypass, not the stale array value. Bench requirement: ACCUM,ACCUM,ACCUM to one address on consecutive cycles accumulates all three errors.
- ACCUM arithmetic, per channel independently:
  - sum = zero-extended old value + sign-extended err, computed in max(DATA_W,ERR_W)+2 bits signed.
  - Result clamped to [0, 2^DATA_W-1].
  - No cross-channel carry.
- Out-of-range address (op_addr >= DEPTH):
  - WRITE/ACCUM: writeback suppressed.
  - READ/ACCUM: rd_valid=1, rd_data=0.
  - addr_err set.
- clear_req and op_valid in the same RUN cycle: the op is accepted, then DRAIN begins.
- clear_req during CLEAR or DRAIN: ignored (no restart).
- Reset asserted mid-sweep or mid-op: sweep restarts from 0 after release; dropped ops produce no rd_valid.
- rd_data holds its last value when rd_valid=0.

Test Plan:
1. Reset release -> busy=1 for exactly 4096 cycles (64x64 defaults), then op_ready=1; READ addr 0 and addr 4095 -> rd_data=0x000000 at N+2.
2. WRITE addr 5 = 0x80_40_FF, then READ addr 5 on the next cycle (bypass) -> rd_valid at N+3 with 0x80_40_FF.
3. WRITE addr 7 = 0x10_F0_80; ACCUM addr 7 err per channel (+20, +20, -200); ACCUM again err (-30, +0, +0) on consecutive cycles:
   - first rd_data = 0x24_FF_00 (+20 on 0x10, 0xF0 saturates high, 0x80 saturates low);
   - second rd_data = 0x06_FF_00.
4. READ addr 4096 -> rd_valid with rd_data=0, addr_err=1; the array is unmodified (READ addr 4095 unchanged).
5. Issue ACCUM at cycle N with clear_req=1 -> that ACCUM's rd_valid still fires at N+2; busy=1 from N+1 for 2+4096 cycles; memory all zero afterwards; addr_err cleared.
6. Assert reset at sweep counter=1000, release -> full 4096-cycle sweep restarts; an op pending at reset never produces rd_valid.
